traffic_sequencer: RTL and testbench
====================================

# traffic_sequencer

Two-road intersection light controller: consumes the one-cycle 1 Hz enable produced by the divider (`oneHz_Enable`) and sequences the main (NS) and side (EW) road signals through fixed-duration phases. It adds a side-road car sensor and a pedestrian push-button with an acknowledge pulse. It sits directly downstream of the divider, and both blocks share `clk` and `Reset_Sync`.

## Interface
- `NS_GREEN_MIN`, 10: minimum NS green, in ticks
- `EW_GREEN`, 6: EW green, in ticks
- `YELLOW`, 3: yellow duration for either road, in ticks
- `ALL_RED`, 1: all-red clearance, in ticks
- `WALK`, 5: pedestrian walk, in ticks
- All durations are 1..255; the timer is 8 bits.

- `clk` in 1: system clock, single domain
- `Reset_Sync` in 1: reset, synchronous, active-high
- `oneHz_Enable` in 1: one-cycle tick from the divider
- `side_car` in 1: EW car sensor, level
- `ped_req` in 1: pedestrian button, level; rising edge is the request
- `ns_light` out 3: {R,Y,G}, one-hot
- `ew_light` out 3: {R,Y,G}, one-hot
- `walk` out 1: walk lamp
- `ped_ack` out 1: one-cycle pulse when a new request is latched
- `phase` out 3: state encoding, for debug and the bench

## Operation
- States and `phase` codes:
  - NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, PED_WALK=3
  - EW_GREEN=4, EW_YELLOW=5, ALL_RED_B=6
- Outputs are a Moore decode of the state register:
  - NS_GREEN: NS=G, EW=R.
  - NS_YELLOW: NS=Y, EW=R.
  - EW_GREEN: NS=R, EW=G.
  - EW_YELLOW: NS=R, EW=Y.
  - ALL_RED_A, ALL_RED_B and PED_WALK: both roads R.
  - `walk`=1 only in PED_WALK.
- Timer behaviour:
  - On state entry the timer loads that state's duration.
  - Each cycle with `oneHz_Enable`=1, a nonzero timer decrements.
  - A state "expires" on the tick that takes the timer from 1 to 0, so every timed state lasts exactly its duration in ticks.
- Transitions, each taken on the clock edge where expiry occurs:
  - NS_GREEN → NS_YELLOW: only when expired (timer=0, saturated) and (`car_pend` or `ped_pend`). Otherwise NS holds green indefinitely. If a request arrives after expiry, the transition happens on the next cycle; no tick is needed.
  - NS_YELLOW → ALL_RED_A.
  - ALL_RED_A → PED_WALK if `ped_pend`, else EW_GREEN.
  - PED_WALK → EW_GREEN if `car_pend`, else ALL_RED_B.
  - EW_GREEN → EW_YELLOW.
  - EW_YELLOW → ALL_RED_B.
  - ALL_RED_B → NS_GREEN.
- `car_pend`:
  - Set by `side_car`=1 in any cycle.
  - Cleared on entry to EW_GREEN.
  - If set and clear occur in the same cycle, set wins.
- `ped_pend`:
  - Set on a registered rising-edge detect of `ped_req`.
  - Cleared on entry to PED_WALK.
  - If set and clear occur in the same cycle, set wins.
- `ped_ack`:
  - Pulses for one cycle, the cycle after a rising edge that sets `ped_pend` while it was clear.
  - No ack for a redundant press while pending.
- Reset:
  - State ALL_RED_B, timer=`ALL_RED`.
  - Pending flags 0, edge-detect register 0.
  - Outputs: `ns_light`=`ew_light`=3'b100, `walk`=0, `ped_ack`=0, `phase`=6.
- Reset asserted mid-phase wins over any tick or request in the same cycle.
- Safety invariant: both roads are never non-red simultaneously.

## Timing
- A tick is counted in the cycle it is high; the state register changes on that same edge, and outputs change at that edge (zero added latency).
- Ticks during reset are ignored.
- After reset deasserts, the first tick expires ALL_RED_B (with `ALL_RED`=1), and NS goes green on that edge.
- NS green minimum runs from the entry edge, counting `NS_GREEN_MIN` ticks.
- Request-to-yellow latency:
  - When the timer has already expired: 2 cycles (latch, then transition).
  - Otherwise: at the expiry tick.
- `ped_ack` latency: 2 cycles after the `ped_req` rising edge (edge register, then latch/ack).

## Test plan
- Reset, then 1 tick → `phase` 6→0, `ns_light`=001, `ew_light`=100; with no requests, `phase` stays 0 for 30 ticks.
- Assert `side_car` for 1 cycle at tick 3 of NS green → yellow on tick 10. Phase sequence 1(3 ticks), 2(1), 4(6), 5(3), 6(1), 0. `walk` never 1.
- Press `ped_req` at tick 2 → `ped_ack` pulses once, 2 cycles later. Then NS_YELLOW, ALL_RED_A, PED_WALK with `walk`=1 for 5 ticks, then ALL_RED_B, then 0; EW never green.
- Press `ped_req` and raise `side_car` together → PED_WALK then EW_GREEN. Both flags are cleared afterwards; a second press while pending gives no `ped_ack`.
- Press `ped_req` during PED_WALK → it is latched and acked, and served on the next NS→red cycle.
- Assert reset during EW_GREEN with a tick in the same cycle → `phase`=6, all red, flags cleared. Checker throughout: no cycle with both roads non-red; lights always one-hot.

Source files
------------

// File: rtl/traffic_sequencer_if.sv
// Bus bundle for the intersection light controller.
//   oneHz_Enable : one-cycle tick from the upstream divider
//   side_car     : EW car sensor (level)
//   ped_req      : pedestrian button (level, rising edge = request)
//   ns_light     : NS lamps {R,Y,G}, one-hot
//   ew_light     : EW lamps {R,Y,G}, one-hot
//   walk         : pedestrian walk lamp
//   ped_ack      : one-cycle pulse when a new pedestrian request is latched
//   phase        : current state code (debug)
// master drives the inputs and observes the lamps; slave is the controller.
interface traffic_sequencer_if;
  logic       oneHz_Enable;
  logic       side_car;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output oneHz_Enable, side_car, ped_req,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  oneHz_Enable, side_car, ped_req,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/traffic_sequencer.sv
// Two-road intersection light controller.
// Sequences the NS (main) and EW (side) lamps through timed phases counted in
// 1 Hz ticks, with a side-road car sensor and a pedestrian button.
//   clk        : system clock
//   Reset_Sync : synchronous active-high reset
//   bus        : traffic_sequencer_if.slave (tick, sensors, lamps, ack, phase)
// Lamp outputs are a Moore decode of the state register.
module traffic_sequencer #(
  parameter int unsigned NS_GREEN_MIN = 10,
  parameter int unsigned EW_GREEN     = 6,
  parameter int unsigned YELLOW       = 3,
  parameter int unsigned ALL_RED      = 1,
  parameter int unsigned WALK         = 5
) (
  input logic                  clk,
  input logic                  Reset_Sync,
  traffic_sequencer_if.slave   bus
);

  localparam logic [2:0] S_NS_GREEN  = 3'd0;
  localparam logic [2:0] S_NS_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED_A = 3'd2;
  localparam logic [2:0] S_PED_WALK  = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_ALL_RED_B = 3'd6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state, state_nx;
  logic [7:0] timer, timer_nx;
  logic       tick;
  logic       expired;
  logic       car_pend, ped_pend;
  logic       ped_d, ped_rise;
  logic       ped_ack_q;
  logic       enter_ew, enter_walk;

  assign tick = bus.oneHz_Enable;

  function automatic logic [7:0] duration(input logic [2:0] s);
    case (s)
      S_NS_GREEN:               duration = 8'(NS_GREEN_MIN);
      S_NS_YELLOW, S_EW_YELLOW: duration = 8'(YELLOW);
      S_PED_WALK:               duration = 8'(WALK);
      S_EW_GREEN:               duration = 8'(EW_GREEN);
      default:                  duration = 8'(ALL_RED);
    endcase
  endfunction

  // Expired covers both the 1->0 tick itself and NS green parked at zero,
  // so a late request leaves NS green on the very next cycle.
  always_comb begin
    expired  = (timer == 8'd0) || (tick && (timer == 8'd1));
    state_nx = state;
    case (state)
      S_NS_GREEN:  if (expired && (car_pend || ped_pend)) state_nx = S_NS_YELLOW;
      S_NS_YELLOW: if (expired) state_nx = S_ALL_RED_A;
      S_ALL_RED_A: if (expired) state_nx = ped_pend ? S_PED_WALK : S_EW_GREEN;
      S_PED_WALK:  if (expired) state_nx = car_pend ? S_EW_GREEN : S_ALL_RED_B;
      S_EW_GREEN:  if (expired) state_nx = S_EW_YELLOW;
      S_EW_YELLOW: if (expired) state_nx = S_ALL_RED_B;
      S_ALL_RED_B: if (expired) state_nx = S_NS_GREEN;
      default:     state_nx = S_ALL_RED_B;
    endcase

    // No state loops back to itself, so any change of state is an entry.
    if (state_nx != state)
      timer_nx = duration(state_nx);
    else if (tick && (timer != 8'd0))
      timer_nx = timer - 8'd1;
    else
      timer_nx = timer;

    enter_ew   = (state_nx == S_EW_GREEN) && (state != S_EW_GREEN);
    enter_walk = (state_nx == S_PED_WALK) && (state != S_PED_WALK);
  end

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state     <= S_ALL_RED_B;
      timer     <= 8'(ALL_RED);
      car_pend  <= 1'b0;
      ped_pend  <= 1'b0;
      ped_d     <= 1'b0;
      ped_rise  <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      ped_d     <= bus.ped_req;
      ped_rise  <= bus.ped_req & ~ped_d;
      // A new request outranks a clear in the same cycle.
      car_pend  <= bus.side_car | (car_pend & ~enter_ew);
      ped_pend  <= ped_rise | (ped_pend & ~enter_walk);
      ped_ack_q <= ped_rise & ~ped_pend;
    end
  end

  always_comb begin
    bus.ns_light = LAMP_R;
    bus.ew_light = LAMP_R;
    case (state)
      S_NS_GREEN:  bus.ns_light = LAMP_G;
      S_NS_YELLOW: bus.ns_light = LAMP_Y;
      S_EW_GREEN:  bus.ew_light = LAMP_G;
      S_EW_YELLOW: bus.ew_light = LAMP_Y;
      default:     ;
    endcase
  end

  assign bus.walk    = (state == S_PED_WALK);
  assign bus.ped_ack = ped_ack_q;
  assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer: a vector table for the side-car
// cycle plus hand-written sequences for pedestrian, combined and reset cases.
module tb_traffic_sequencer;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit chk_en = 1'b0;

  traffic_sequencer_if bus();

  traffic_sequencer #(
    .NS_GREEN_MIN(10),
    .EW_GREEN(6),
    .YELLOW(3),
    .ALL_RED(1),
    .WALK(5)
  ) dut (
    .clk(clk),
    .Reset_Sync(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       car;
    logic       ped;
    logic [2:0] ph;
    logic       ack;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mkv(logic t, logic c, logic p, logic [2:0] ph, logic a);
    vec_t v;
    v.tick = t; v.car = c; v.ped = p; v.ph = ph; v.ack = a;
    return v;
  endfunction

  function automatic logic [2:0] exp_ns(logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(logic [2:0] ph);
    case (ph)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [2:0] ph, input logic ack);
    chk({nm, ".phase"}, 8'(bus.phase), 8'(ph));
    chk({nm, ".ns"}, 8'(bus.ns_light), 8'(exp_ns(ph)));
    chk({nm, ".ew"}, 8'(bus.ew_light), 8'(exp_ew(ph)));
    chk({nm, ".walk"}, 8'(bus.walk), 8'(ph == 3'd3));
    chk({nm, ".ack"}, 8'(bus.ped_ack), 8'(ack));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check.
  task automatic step(input logic t, input logic c, input logic p,
                      input logic [2:0] ph, input logic ack, input string nm);
    bus.oneHz_Enable = t;
    bus.side_car     = c;
    bus.ped_req      = p;
    @(negedge clk);
    check_out(nm, ph, ack);
    bus.oneHz_Enable = 1'b0;
  endtask

  task automatic ticks(input int unsigned n, input logic [2:0] ph, input string nm);
    for (int unsigned i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'b0, ph, 1'b0, $sformatf("%s[%0d]", nm, i));
  endtask

  // Reset held two cycles with ticks present; ends with NS freshly green.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    bus.oneHz_Enable = 1'b1;
    bus.side_car = 1'b0;
    bus.ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_out({nm, ".rst"}, 3'd6, 1'b0);
    rst = 1'b0;
    bus.oneHz_Enable = 1'b0;
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 3'd6, 1'b0, {nm, ".idle"});
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, {nm, ".first_tick"});
  endtask

  // Safety checker: lamps one-hot and never both roads non-red.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inv.ns_onehot", 8'($onehot(bus.ns_light)), 8'd1);
      chk("inv.ew_onehot", 8'($onehot(bus.ew_light)), 8'd1);
      chk("inv.not_both_go", 8'((bus.ns_light != 3'b100) && (bus.ew_light != 3'b100)), 8'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Side car asserted on tick 3 of NS green: yellow on tick 10.
    tbl[0]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[1]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[2]  = mkv(1, 1, 0, 3'd0, 0);
    tbl[3]  = mkv(0, 0, 0, 3'd0, 0);
    tbl[4]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[5]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[6]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[7]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[8]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[9]  = mkv(1, 0, 0, 3'd0, 0);
    tbl[10] = mkv(1, 0, 0, 3'd1, 0);
    tbl[11] = mkv(1, 0, 0, 3'd1, 0);
    tbl[12] = mkv(1, 0, 0, 3'd1, 0);
    tbl[13] = mkv(1, 0, 0, 3'd2, 0);
    tbl[14] = mkv(1, 0, 0, 3'd4, 0);
    tbl[15] = mkv(0, 0, 0, 3'd4, 0);
    tbl[16] = mkv(1, 0, 0, 3'd4, 0);
    tbl[17] = mkv(1, 0, 0, 3'd4, 0);
    tbl[18] = mkv(1, 0, 0, 3'd4, 0);
    tbl[19] = mkv(1, 0, 0, 3'd4, 0);
    tbl[20] = mkv(1, 0, 0, 3'd4, 0);
    tbl[21] = mkv(1, 0, 0, 3'd5, 0);
    tbl[22] = mkv(1, 0, 0, 3'd5, 0);
    tbl[23] = mkv(1, 0, 0, 3'd5, 0);
    tbl[24] = mkv(1, 0, 0, 3'd6, 0);
    tbl[25] = mkv(1, 0, 0, 3'd0, 0);

    rst = 1'b1;
    bus.oneHz_Enable = 1'b0;
    bus.side_car = 1'b0;
    bus.ped_req = 1'b0;

    // No requests: NS stays green.
    do_reset("r0");
    ticks(30, 3'd0, "hold");

    // Side-car cycle from the table.
    do_reset("r1");
    foreach (tbl[i])
      step(tbl[i].tick, tbl[i].car, tbl[i].ped, tbl[i].ph, tbl[i].ack,
           $sformatf("vec[%0d]", i));

    // Pedestrian request on tick 2, ack two cycles after the edge.
    do_reset("r2");
    ticks(2, 3'd0, "p.g");
    step(0, 0, 1, 3'd0, 0, "p.press0");
    step(0, 0, 1, 3'd0, 1, "p.ack");
    step(0, 0, 1, 3'd0, 0, "p.ack_end");
    ticks(7, 3'd0, "p.g2");
    ticks(1, 3'd1, "p.y_in");
    ticks(2, 3'd1, "p.y");
    ticks(1, 3'd2, "p.ara");
    ticks(1, 3'd3, "p.walk_in");
    ticks(4, 3'd3, "p.walk");
    ticks(1, 3'd6, "p.arb");
    ticks(1, 3'd0, "p.ns");

    // Pedestrian and car together; redundant press gives no ack.
    step(0, 1, 1, 3'd0, 0, "pc.press");
    step(0, 0, 1, 3'd0, 1, "pc.ack");
    step(0, 0, 1, 3'd0, 0, "pc.ack_end");
    step(0, 0, 0, 3'd0, 0, "pc.release");
    step(0, 0, 1, 3'd0, 0, "pc.redund0");
    step(0, 0, 1, 3'd0, 0, "pc.redund1");
    step(0, 0, 0, 3'd0, 0, "pc.redund2");
    ticks(9, 3'd0, "pc.g");
    ticks(1, 3'd1, "pc.y_in");
    ticks(2, 3'd1, "pc.y");
    ticks(1, 3'd2, "pc.ara");
    ticks(1, 3'd3, "pc.walk_in");
    ticks(4, 3'd3, "pc.walk");
    ticks(1, 3'd4, "pc.ewg_in");
    ticks(5, 3'd4, "pc.ewg");
    ticks(1, 3'd5, "pc.ewy_in");
    ticks(2, 3'd5, "pc.ewy");
    ticks(1, 3'd6, "pc.arb");
    ticks(1, 3'd0, "pc.ns");
    ticks(15, 3'd0, "pc.cleared");

    // Late request with NS already expired: latch, then yellow next cycle.
    step(0, 0, 1, 3'd0, 0, "late.press");
    step(0, 0, 1, 3'd0, 1, "late.ack");
    step(0, 0, 0, 3'd1, 0, "late.yellow");
    ticks(2, 3'd1, "late.y");
    ticks(1, 3'd2, "late.ara");
    ticks(1, 3'd3, "late.walk_in");
    // Press during walk: acked and served next round.
    step(0, 0, 1, 3'd3, 0, "pw.press");
    step(0, 0, 1, 3'd3, 1, "pw.ack");
    step(0, 0, 0, 3'd3, 0, "pw.ack_end");
    ticks(4, 3'd3, "pw.walk");
    ticks(1, 3'd6, "pw.arb");
    ticks(1, 3'd0, "pw.ns_in");
    ticks(9, 3'd0, "pw.g");
    ticks(1, 3'd1, "pw.y_in");
    ticks(2, 3'd1, "pw.y");
    ticks(1, 3'd2, "pw.ara");
    ticks(1, 3'd3, "pw.served");

    // Car during walk leads to EW green; then reset with a tick.
    step(0, 1, 0, 3'd3, 0, "rs.car");
    ticks(4, 3'd3, "rs.walk");
    ticks(1, 3'd4, "rs.ewg_in");
    step(0, 0, 1, 3'd4, 0, "rs.press");
    step(0, 0, 1, 3'd4, 1, "rs.ack");
    step(0, 0, 0, 3'd4, 0, "rs.ack_end");
    ticks(2, 3'd4, "rs.ewg");
    do_reset("r3");
    ticks(13, 3'd0, "rs.cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
